// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_pkg
//  Brief    : Shared constants and the per-bank FILL/FULL state type for the
//             neuron operand feeder.
//  Revision : 1.0 - initial release
// ============================================================================
package neuron_pkg;

    // Default operand width in bits
    localparam int c_DW_DEFAULT = 8;

    // Width of the operand index driven by the neuron
    localparam int c_ADDR_W = 32;

    // A bank either accepts load beats (FILL) or holds a complete set (FULL)
    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } bank_state_t;

endpackage
`default_nettype wire

// File: rtl/operand_bank.sv
`default_nettype none
// ============================================================================
//  Module   : operand_bank
//  Brief    : N-entry x/w operand register file. Beat index 0..N-1 writes the
//             x entries, N..2N-1 writes the w entries. Reads are combinational
//             and return zero for any index outside 0..N-1.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_bank
    import neuron_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = c_DW_DEFAULT,
    parameter int BW = $clog2(2 * N)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [BW-1:0]       i_waddr,
    input  logic [DW-1:0]       i_wdata,
    input  logic [c_ADDR_W-1:0] i_raddr,
    output logic [DW-1:0]       o_x,
    output logic [DW-1:0]       o_w
);

    logic [DW-1:0] r_x [N];
    logic [DW-1:0] r_w [N];

    // Write the addressed entry; storage is deliberately not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (i_we && (i_waddr == BW'(i))) begin
                r_x[i] <= i_wdata;
            end
            if (i_we && (i_waddr == BW'(i + N))) begin
                r_w[i] <= i_wdata;
            end
        end
    end

    // Zero-latency read; unmatched indices fall through to zero
    always_comb begin
        o_x = '0;
        o_w = '0;
        for (int i = 0; i < N; i++) begin
            if (i_raddr == c_ADDR_W'(i)) begin
                o_x = r_x[i];
                o_w = r_w[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : operand_feeder
//  Brief    : Collects 2N load beats (x[0..N-1] then w[0..N-1]) into an
//             operand bank and serves the completed set to a neuron by index.
//             Define OPERAND_FEEDER_PINGPONG_EN for double buffering, so the
//             next set can load while the current one is being served.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_feeder
    import neuron_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = c_DW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_valid,
    input  logic [DW-1:0]       ld_data,
    output logic                ld_ready,
    input  logic [c_ADDR_W-1:0] Adr,
    output logic [DW-1:0]       x,
    output logic [DW-1:0]       w,
    output logic                bank_ready,
    input  logic                consume
);

    localparam int              c_BEATS = 2 * N;
    localparam int              c_BW    = $clog2(c_BEATS);
    localparam logic [c_BW-1:0] c_LAST  = c_BW'(c_BEATS - 1);
    localparam logic [c_BW-1:0] c_ONE   = c_BW'(1);

    logic [c_BW-1:0] r_cnt;
    logic            w_accept;
    logic            w_last;
    logic            w_consume;
    logic [DW-1:0]   w_rd_x;
    logic [DW-1:0]   w_rd_w;

    assign w_accept  = ld_valid & ld_ready;
    assign w_last    = w_accept && (r_cnt == c_LAST);
    assign w_consume = consume & bank_ready;

    // Beat counter: advances per accepted beat, wraps after the last beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + c_ONE;
        end
    end

`ifdef OPERAND_FEEDER_PINGPONG_EN

    bank_state_t   r_state    [2];
    bank_state_t   w_state_nx [2];
    logic          r_fill_idx;
    logic          r_srv_idx;
    logic          w_fill_nx;
    logic          w_srv_nx;
    logic [DW-1:0] w_bank_x   [2];
    logic [DW-1:0] w_bank_w   [2];

    assign ld_ready   = (r_state[r_fill_idx] == FILL);
    assign bank_ready = (r_state[r_srv_idx] == FULL);
    assign w_rd_x     = w_bank_x[r_srv_idx];
    assign w_rd_w     = w_bank_w[r_srv_idx];

    // Bank state and index update. A consume and a completing fill may land
    // in the same cycle: they always touch different banks. The fill index
    // moves on whenever its bank is full and the other bank is free, which
    // also covers the case where the other bank is freed later by a consume.
    always_comb begin
        w_state_nx[0] = r_state[0];
        w_state_nx[1] = r_state[1];
        w_srv_nx      = r_srv_idx;
        w_fill_nx     = r_fill_idx;
        if (w_consume) begin
            w_state_nx[r_srv_idx] = FILL;
            w_srv_nx              = ~r_srv_idx;
        end
        if (w_last) begin
            w_state_nx[r_fill_idx] = FULL;
        end
        if ((w_state_nx[r_fill_idx] == FULL) && (w_state_nx[~r_fill_idx] == FILL)) begin
            w_fill_nx = ~r_fill_idx;
        end
    end

    // Bank state and index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state[0] <= FILL;
            r_state[1] <= FILL;
            r_fill_idx <= 1'b0;
            r_srv_idx  <= 1'b0;
        end else begin
            r_state[0] <= w_state_nx[0];
            r_state[1] <= w_state_nx[1];
            r_fill_idx <= w_fill_nx;
            r_srv_idx  <= w_srv_nx;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        operand_bank #(
            .N  (N),
            .DW (DW),
            .BW (c_BW)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_accept && (r_fill_idx == 1'(b))),
            .i_waddr (r_cnt),
            .i_wdata (ld_data),
            .i_raddr (Adr),
            .o_x     (w_bank_x[b]),
            .o_w     (w_bank_w[b])
        );
    end

`else

    bank_state_t r_state;
    bank_state_t w_state_nx;

    assign ld_ready   = (r_state == FILL);
    assign bank_ready = (r_state == FULL);

    // Single bank: fills to FULL on the last beat, frees on consume
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            FILL:    if (w_last)    w_state_nx = FULL;
            FULL:    if (w_consume) w_state_nx = FILL;
            default: w_state_nx = FILL;
        endcase
    end

    // Bank state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nx;
        end
    end

    operand_bank #(
        .N  (N),
        .DW (DW),
        .BW (c_BW)
    ) u_bank (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_cnt),
        .i_wdata (ld_data),
        .i_raddr (Adr),
        .o_x     (w_rd_x),
        .o_w     (w_rd_w)
    );

`endif

    // Operands are only visible while a complete set is served
    assign x = bank_ready ? w_rd_x : '0;
    assign w = bank_ready ? w_rd_w : '0;

endmodule
`default_nettype wire

// File: tb/tb_operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_feeder
//  Brief    : Self-checking bench for operand_feeder (N=3, DW=8). A queue of
//             completed operand sets models the feeder's behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_feeder;

    localparam int N  = 3;
    localparam int DW = 8;
`ifdef OPERAND_FEEDER_PINGPONG_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data  = '0;
    logic [31:0]   Adr      = '0;
    logic          consume  = 1'b0;
    logic          ld_ready;
    logic          bank_ready;
    logic [DW-1:0] x;
    logic [DW-1:0] w;

    operand_feeder #(.N(N), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .Adr        (Adr),
        .x          (x),
        .w          (w),
        .bank_ready (bank_ready),
        .consume    (consume)
    );

    always #5 clk = ~clk;

    typedef logic [2*N-1:0][DW-1:0] set_t;

    set_t mq[$];
    set_t pset;
    int   pbeat  = 0;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [DW-1:0] exp_x(input int a);
        if (mq.size() == 0 || a >= N) return '0;
        return mq[0][a];
    endfunction

    function automatic logic [DW-1:0] exp_w(input int a);
        if (mq.size() == 0 || a >= N) return '0;
        return mq[0][N + a];
    endfunction

    function automatic logic exp_ldr();
        return (mq.size() < CAP) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic exp_brdy();
        return (mq.size() > 0) ? 1'b1 : 1'b0;
    endfunction

    // One clock with the given inputs; model updated at the edge
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic c);
        bit acc;
        bit con;
        ld_valid = v;
        ld_data  = d;
        consume  = c;
        acc = v && (mq.size() < CAP);
        con = c && (mq.size() > 0);
        @(posedge clk);
        if (con) void'(mq.pop_front());
        if (acc) begin
            pset[pbeat] = d;
            pbeat++;
            if (pbeat == 2 * N) begin
                mq.push_back(pset);
                pbeat = 0;
            end
        end
        #1;
        ld_valid = 1'b0;
        consume  = 1'b0;
    endtask

    task automatic load_set(input int b0, b1, b2, b3, b4, b5);
        cycle(1'b1, DW'(b0), 1'b0);
        cycle(1'b1, DW'(b1), 1'b0);
        cycle(1'b1, DW'(b2), 1'b0);
        cycle(1'b1, DW'(b3), 1'b0);
        cycle(1'b1, DW'(b4), 1'b0);
        cycle(1'b1, DW'(b5), 1'b0);
    endtask

    task automatic drain();
        while (mq.size() > 0) cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mq.delete();
        pbeat = 0;
        Adr = 0;
        #3;
        checks++; if (ld_ready !== 1'b1)   begin errors++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
        checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL reset_bank_ready got %b want 0", bank_ready); end
        checks++; if (x !== 8'd0)          begin errors++; $display("FAIL reset_x got %0d want 0", x); end
        checks++; if (w !== 8'd0)          begin errors++; $display("FAIL reset_w got %0d want 0", w); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_basic_load();
        cycle(1'b1, 8'd10, 1'b0);
        cycle(1'b1, 8'd20, 1'b0);
        cycle(1'b1, 8'd30, 1'b0);
        cycle(1'b1, 8'd1, 1'b0);
        cycle(1'b1, 8'd2, 1'b0);
        checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL basic_early_ready got %b want 0", bank_ready); end
        cycle(1'b1, 8'd3, 1'b0);
        checks++; if (bank_ready !== 1'b1) begin errors++; $display("FAIL basic_bank_ready got %b want 1", bank_ready); end
        checks++; if (ld_ready !== exp_ldr()) begin errors++; $display("FAIL basic_ld_ready got %b want %b", ld_ready, exp_ldr()); end
        Adr = 1; #1;
        checks++; if (x !== 8'd20) begin errors++; $display("FAIL basic_x1 got %0d want 20", x); end
        checks++; if (w !== 8'd2)  begin errors++; $display("FAIL basic_w1 got %0d want 2", w); end
        Adr = 3; #1;
        checks++; if (x !== 8'd0 || w !== 8'd0) begin errors++; $display("FAIL basic_adr3 got x=%0d w=%0d want 0 0", x, w); end
        Adr = 0; #1;
        checks++; if (x !== 8'd10 || w !== 8'd1) begin errors++; $display("FAIL basic_adr0 got x=%0d w=%0d want 10 1", x, w); end
        drain();
        checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL basic_consume got %b want 0", bank_ready); end
    endtask

    task automatic test_mid_reset();
        cycle(1'b1, 8'd91, 1'b0);
        cycle(1'b1, 8'd92, 1'b0);
        cycle(1'b1, 8'd93, 1'b0);
        cycle(1'b1, 8'd94, 1'b0);
        rst = 1'b0;
        mq.delete();
        pbeat = 0;
        #2;
        checks++; if (ld_ready !== 1'b1 || bank_ready !== 1'b0) begin errors++; $display("FAIL midrst_flags got ldr=%b brdy=%b want 1 0", ld_ready, bank_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        load_set(5, 6, 7, 8, 9, 4);
        Adr = 2; #1;
        checks++; if (x !== 8'd7 || w !== 8'd4) begin errors++; $display("FAIL midrst_data got x=%0d w=%0d want 7 4", x, w); end
        checks++; if (bank_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", bank_ready); end
        drain();
    endtask

    task automatic test_ignored();
        cycle(1'b0, '0, 1'b1);
        checks++; if (ld_ready !== 1'b1 || bank_ready !== 1'b0) begin errors++; $display("FAIL ign_consume got ldr=%b brdy=%b want 1 0", ld_ready, bank_ready); end
        for (int s = 0; s < CAP; s++) load_set(40 + s, 41 + s, 42 + s, 43 + s, 44 + s, 45 + s);
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL ign_full_ld_ready got %b want 0", ld_ready); end
        cycle(1'b1, 8'hEE, 1'b0);
        cycle(1'b1, 8'hDD, 1'b0);
        for (int a = 0; a < N; a++) begin
            Adr = a; #1;
            checks++;
            if (x !== DW'(40 + a) || w !== DW'(43 + a)) begin
                errors++; $display("FAIL ign_data adr=%0d got x=%0d w=%0d want %0d %0d", a, x, w, 40 + a, 43 + a);
            end
        end
        drain();
        // The ignored beats must not have moved the beat counter
        load_set(60, 61, 62, 63, 64, 65);
        Adr = 1; #1;
        checks++; if (x !== 8'd61 || w !== 8'd64) begin errors++; $display("FAIL ign_counter got x=%0d w=%0d want 61 64", x, w); end
        drain();
    endtask

`ifdef OPERAND_FEEDER_PINGPONG_EN
    task automatic test_pingpong();
        load_set(1, 2, 3, 4, 5, 6);
        load_set(11, 12, 13, 14, 15, 16);
        Adr = 0; #1;
        checks++; if (x !== 8'd1 || bank_ready !== 1'b1) begin errors++; $display("FAIL pp_served_a got x=%0d brdy=%b want 1 1", x, bank_ready); end
        cycle(1'b0, '0, 1'b1);
        checks++; if (x !== 8'd11 || w !== 8'd14 || bank_ready !== 1'b1) begin errors++; $display("FAIL pp_served_b got x=%0d w=%0d brdy=%b want 11 14 1", x, w, bank_ready); end
        cycle(1'b0, '0, 1'b1);
        checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL pp_empty got %b want 0", bank_ready); end
        load_set(21, 22, 23, 24, 25, 26);
        cycle(1'b1, 8'd31, 1'b0);
        cycle(1'b1, 8'd32, 1'b0);
        cycle(1'b1, 8'd33, 1'b0);
        cycle(1'b1, 8'd34, 1'b0);
        cycle(1'b1, 8'd35, 1'b0);
        cycle(1'b1, 8'd36, 1'b1);
        Adr = 2; #1;
        checks++; if (x !== 8'd33 || w !== 8'd36 || bank_ready !== 1'b1) begin errors++; $display("FAIL pp_coincide_data got x=%0d w=%0d brdy=%b want 33 36 1", x, w, bank_ready); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL pp_coincide_ld_ready got %b want 1", ld_ready); end
        drain();
    endtask
`endif

    task automatic test_random();
        logic [DW-1:0] ex;
        logic [DW-1:0] ew;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 5) == 0));
            Adr = $urandom_range(0, 4);
            #1;
            ex = exp_x(int'(Adr));
            ew = exp_w(int'(Adr));
            checks++; if (ld_ready !== exp_ldr())    begin errors++; $display("FAIL rand_ld_ready cyc=%0d got %b want %b", i, ld_ready, exp_ldr()); end
            checks++; if (bank_ready !== exp_brdy()) begin errors++; $display("FAIL rand_bank_ready cyc=%0d got %b want %b", i, bank_ready, exp_brdy()); end
            checks++; if (x !== ex) begin errors++; $display("FAIL rand_x cyc=%0d adr=%0d got %0d want %0d", i, Adr, x, ex); end
            checks++; if (w !== ew) begin errors++; $display("FAIL rand_w cyc=%0d adr=%0d got %0d want %0d", i, Adr, w, ew); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_mid_reset();
        test_ignored();
`ifdef OPERAND_FEEDER_PINGPONG_EN
        test_pingpong();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
